// File: rtl/dma_periph_channel.sv
// Single-channel peripheral DMA engine: answers a dma_req/dma_ack/dma_done handshake and
// copies a word block from source to destination as an AHB-Lite master, one beat at a time.
module dma_periph_channel #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   HCLK,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ADDR_WIDTH-1:0]  src_addr,
  input  logic [ADDR_WIDTH-1:0]  dst_addr,
  input  logic                   src_inc,
  input  logic                   dst_inc,
  input  logic [COUNT_WIDTH-1:0] xfer_count,
  input  logic                   irq_clear,
  input  logic                   dma_req,
  output logic                   dma_ack,
  output logic                   dma_done,
  output logic [ADDR_WIDTH-1:0]  haddr,
  output logic [1:0]             htrans,
  output logic                   hwrite,
  output logic [2:0]             hsize,
  output logic [DATA_WIDTH-1:0]  hwdata,
  input  logic [DATA_WIDTH-1:0]  hrdata,
  input  logic                   hready,
  output logic                   busy,
  output logic                   done_irq,
  output logic                   abort_flag
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    DONE
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  cur_src;
  logic [ADDR_WIDTH-1:0]  cur_dst;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   src_inc_q;
  logic                   dst_inc_q;
  logic [ADDR_WIDTH-1:0]  src_next;
  logic [ADDR_WIDTH-1:0]  dst_next;

  // Post-beat addresses; the adders wrap modulo 2^ADDR_WIDTH by construction.
  assign src_next = src_inc_q ? cur_src + ADDR_WIDTH'(4) : cur_src;
  assign dst_next = dst_inc_q ? cur_dst + ADDR_WIDTH'(4) : cur_dst;
  assign hsize    = 3'b010;

  always_ff @(posedge HCLK) begin
    if (reset) begin
      state      <= IDLE;
      cur_src    <= '0;
      cur_dst    <= '0;
      remaining  <= '0;
      src_inc_q  <= 1'b0;
      dst_inc_q  <= 1'b0;
      dma_ack    <= 1'b0;
      dma_done   <= 1'b0;
      haddr      <= '0;
      htrans     <= TRANS_IDLE;
      hwrite     <= 1'b0;
      hwdata     <= '0;
      busy       <= 1'b0;
      done_irq   <= 1'b0;
      abort_flag <= 1'b0;
    end else begin
      dma_ack  <= 1'b0;
      dma_done <= 1'b0;
      // The DONE branch below assigns later, so a set in the same cycle beats a clear.
      if (irq_clear) done_irq <= 1'b0;

      case (state)
        IDLE: begin
          if (enable && dma_req) begin
            state      <= ACK;
            dma_ack    <= 1'b1;
            busy       <= 1'b1;
            abort_flag <= 1'b0;
            cur_src    <= src_addr;
            cur_dst    <= dst_addr;
            remaining  <= xfer_count;
            src_inc_q  <= src_inc;
            dst_inc_q  <= dst_inc;
          end
        end

        ACK: begin
          if (remaining == '0) begin
            state    <= DONE;
            dma_done <= 1'b1;
          end else begin
            state  <= RD_ADDR;
            haddr  <= cur_src;
            htrans <= TRANS_NONSEQ;
            hwrite <= 1'b0;
          end
        end

        RD_ADDR: begin
          if (hready) begin
            state  <= RD_DATA;
            htrans <= TRANS_IDLE;
          end
        end

        // hwdata doubles as the single-word buffer between the read and the write beat.
        RD_DATA: begin
          if (hready) begin
            hwdata <= hrdata;
            state  <= WR_ADDR;
            haddr  <= cur_dst;
            htrans <= TRANS_NONSEQ;
            hwrite <= 1'b1;
          end
        end

        WR_ADDR: begin
          if (hready) begin
            state  <= WR_DATA;
            htrans <= TRANS_IDLE;
          end
        end

        // enable is only looked at here, so a started beat always finishes.
        WR_DATA: begin
          if (hready) begin
            remaining <= remaining - COUNT_WIDTH'(1);
            cur_src   <= src_next;
            cur_dst   <= dst_next;
            hwrite    <= 1'b0;
            if (remaining == COUNT_WIDTH'(1)) begin
              state    <= DONE;
              dma_done <= 1'b1;
            end else if (!enable) begin
              state      <= IDLE;
              busy       <= 1'b0;
              abort_flag <= 1'b1;
            end else begin
              state  <= RD_ADDR;
              haddr  <= src_next;
              htrans <= TRANS_NONSEQ;
            end
          end
        end

        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done_irq <= 1'b1;
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          htrans <= TRANS_IDLE;
          hwrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_periph_channel.sv
// Self-checking bench for dma_periph_channel: an AHB slave model with programmable wait states
// checks every bus beat against a scoreboard filled when each transfer is programmed.
module tb_dma_periph_channel;

  logic        HCLK = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic        src_inc;
  logic        dst_inc;
  logic [15:0] xfer_count;
  logic        irq_clear;
  logic        dma_req;
  logic        dma_ack;
  logic        dma_done;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata = 32'h0;
  logic        hready = 1'b1;
  logic        busy;
  logic        done_irq;
  logic        abort_flag;

  int assert_count = 0;
  int fail_count   = 0;
  int wait_states  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] rd_q[$];
  wr_t         wr_q[$];

  logic        in_data = 1'b0;
  logic        data_write;
  logic [31:0] data_addr;
  int          wait_left;
  wr_t         wr_exp;

  dma_periph_channel dut (
    .HCLK       (HCLK),
    .reset      (reset),
    .enable     (enable),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .src_inc    (src_inc),
    .dst_inc    (dst_inc),
    .xfer_count (xfer_count),
    .irq_clear  (irq_clear),
    .dma_req    (dma_req),
    .dma_ack    (dma_ack),
    .dma_done   (dma_done),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hrdata     (hrdata),
    .hready     (hready),
    .busy       (busy),
    .done_irq   (done_irq),
    .abort_flag (abort_flag)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Slave model: address phases always ready, data phases stretched by wait_states.
  always @(negedge HCLK) begin
    if (reset) begin
      in_data = 1'b0;
      hready  = 1'b1;
    end else if (in_data) begin
      checkOutput("dp_htrans", 64'(htrans), 64'(2'b00));
      checkOutput("dp_haddr", 64'(haddr), 64'(data_addr));
      checkOutput("dp_hwrite", 64'(hwrite), 64'(data_write));
      if (wait_left > 0) begin
        hready = 1'b0;
        wait_left--;
      end else begin
        hready  = 1'b1;
        in_data = 1'b0;
        if (data_write) begin
          if (wr_q.size() == 0) begin
            checkOutput("wr_unexpected", 64'(wr_q.size()), 64'd1);
          end else begin
            wr_exp = wr_q.pop_front();
            checkOutput("wr_addr", 64'(data_addr), 64'(wr_exp.addr));
            checkOutput("wr_data", 64'(hwdata), 64'(wr_exp.data));
          end
        end else begin
          hrdata = mem_word(data_addr);
        end
      end
    end else begin
      hready = 1'b1;
      if (htrans == 2'b10) begin
        in_data    = 1'b1;
        data_addr  = haddr;
        data_write = hwrite;
        wait_left  = wait_states;
        if (!hwrite) begin
          if (rd_q.size() == 0) checkOutput("rd_unexpected", 64'(rd_q.size()), 64'd1);
          else checkOutput("rd_addr", 64'(haddr), 64'(rd_q.pop_front()));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input logic sinc,
                               input logic dinc, input int count, input int n_expect);
    logic [31:0] ra;
    logic [31:0] wa;
    src_addr   = src;
    dst_addr   = dst;
    src_inc    = sinc;
    dst_inc    = dinc;
    xfer_count = 16'(count);
    for (int i = 0; i < n_expect; i++) begin
      ra = src + (sinc ? 32'(4 * i) : 32'd0);
      wa = dst + (dinc ? 32'(4 * i) : 32'd0);
      rd_q.push_back(ra);
      wr_q.push_back('{addr: wa, data: mem_word(ra)});
    end
  endtask

  // Pulses dma_req, then tracks cycles k after the accept edge (k=1 is the ACK cycle).
  task automatic runTransfer(input int exp_done_k, input int drop_k, input bit race, input int max_k);
    int done_k;
    int done_cnt;
    int ack_cnt;
    int k;
    done_k   = -1;
    done_cnt = 0;
    ack_cnt  = 0;
    @(negedge HCLK);
    dma_req = 1'b1;
    @(negedge HCLK);
    dma_req = 1'b0;
    checkOutput("ack_pulse", 64'(dma_ack), 64'd1);
    checkOutput("abort_clr_at_accept", 64'(abort_flag), 64'd0);
    checkOutput("busy_in_ack", 64'(busy), 64'd1);
    src_addr   = $urandom;
    dst_addr   = $urandom;
    xfer_count = 16'($urandom);
    k = 1;
    while (busy && k < max_k) begin
      @(negedge HCLK);
      k++;
      irq_clear = 1'b0;
      if (dma_ack) ack_cnt++;
      if (dma_done) begin
        done_cnt++;
        done_k = k;
        if (race) irq_clear = 1'b1;
      end
      if (k == drop_k) enable = 1'b0;
    end
    irq_clear = 1'b0;
    checkOutput("idle_within_budget", 64'(busy), 64'd0);
    checkOutput("extra_ack", 64'(ack_cnt), 64'd0);
    if (exp_done_k > 0) begin
      checkOutput("done_count", 64'(done_cnt), 64'd1);
      checkOutput("done_cycle", 64'(done_k), 64'(exp_done_k));
    end else begin
      checkOutput("no_done", 64'(done_cnt), 64'd0);
    end
    checkOutput("rd_q_drained", 64'(rd_q.size()), 64'd0);
    checkOutput("wr_q_drained", 64'(wr_q.size()), 64'd0);
  endtask

  task automatic clearIrq();
    @(negedge HCLK);
    irq_clear = 1'b1;
    @(negedge HCLK);
    irq_clear = 1'b0;
    checkOutput("irq_cleared", 64'(done_irq), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    reset      = 1'b1;
    enable     = 1'b1;
    src_addr   = '0;
    dst_addr   = '0;
    src_inc    = 1'b0;
    dst_inc    = 1'b0;
    xfer_count = '0;
    irq_clear  = 1'b0;
    dma_req    = 1'b0;
    repeat (3) @(negedge HCLK);
    checkOutput("rst_htrans", 64'(htrans), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_ack", 64'(dma_ack), 64'd0);
    checkOutput("rst_done", 64'(dma_done), 64'd0);
    checkOutput("rst_irq", 64'(done_irq), 64'd0);
    checkOutput("rst_abort", 64'(abort_flag), 64'd0);
    checkOutput("rst_haddr", 64'(haddr), 64'd0);
    checkOutput("rst_hwdata", 64'(hwdata), 64'd0);
    checkOutput("rst_hwrite", 64'(hwrite), 64'd0);
    checkOutput("hsize", 64'(hsize), 64'(3'b010));
    reset = 1'b0;

    $display("[TB] basic transfer");
    applyStimulus(32'h2000_0000, 32'h4001_0010, 1'b1, 1'b0, 3, 3);
    runTransfer(14, -1, 1'b0, 60);
    checkOutput("basic_irq", 64'(done_irq), 64'd1);
    clearIrq();

    $display("[TB] wait states");
    wait_states = 3;
    applyStimulus(32'h2000_1000, 32'h2000_2000, 1'b1, 1'b1, 2, 2);
    runTransfer(22, -1, 1'b0, 80);
    checkOutput("wait_irq", 64'(done_irq), 64'd1);
    wait_states = 0;
    clearIrq();

    $display("[TB] zero count");
    applyStimulus(32'h2000_3000, 32'h2000_4000, 1'b1, 1'b1, 0, 0);
    runTransfer(2, -1, 1'b0, 20);
    checkOutput("zero_irq", 64'(done_irq), 64'd1);
    clearIrq();

    $display("[TB] abort");
    applyStimulus(32'h2100_0000, 32'h4000_0000, 1'b1, 1'b0, 5, 2);
    runTransfer(-1, 7, 1'b0, 60);
    checkOutput("abort_flag", 64'(abort_flag), 64'd1);
    checkOutput("abort_irq", 64'(done_irq), 64'd0);
    enable = 1'b1;

    $display("[TB] address wrap and irq race");
    applyStimulus(32'hFFFF_FFFC, 32'h4000_0020, 1'b1, 1'b0, 2, 2);
    runTransfer(10, -1, 1'b1, 40);
    checkOutput("race_irq_set_wins", 64'(done_irq), 64'd1);
    checkOutput("wrap_abort_clear", 64'(abort_flag), 64'd0);

    $display("[TB] reset mid-transfer");
    applyStimulus(32'h2200_0000, 32'h2300_0000, 1'b1, 1'b1, 3, 3);
    @(negedge HCLK);
    dma_req = 1'b1;
    @(negedge HCLK);
    dma_req = 1'b0;
    k = 0;
    while (!(htrans == 2'b10 && hwrite == 1'b1) && k < 50) begin
      @(negedge HCLK);
      k++;
    end
    checkOutput("reached_wr_addr", 64'({htrans, hwrite}), 64'(3'b101));
    reset = 1'b1;
    @(posedge HCLK);
    #1;
    checkOutput("mid_rst_htrans", 64'(htrans), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_done", 64'(dma_done), 64'd0);
    checkOutput("mid_rst_irq", 64'(done_irq), 64'd0);
    checkOutput("mid_rst_abort", 64'(abort_flag), 64'd0);
    checkOutput("mid_rst_hwrite", 64'(hwrite), 64'd0);
    @(negedge HCLK);
    @(negedge HCLK);
    rd_q.delete();
    wr_q.delete();
    reset = 1'b0;

    applyStimulus(32'h1000_0100, 32'h3000_0000, 1'b1, 1'b1, 2, 2);
    runTransfer(10, -1, 1'b0, 40);
    checkOutput("rerun_irq", 64'(done_irq), 64'd1);

    repeat (2) @(negedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
